pipe_hazard_ctrl: RTL and testbench
===================================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Sequencer for the 5-stage pipeline: emits per-stage write-enable/flush/bubble controls.
//  Handles ID-stage branch operand stalls, load-use stalls, taken branch/jump flushes and
//  multi-cycle data-memory waits with a timeout.
//  Sits beside Control; drives PC, IFID, IDEX, EXMEM and MEMWB enables.
// PARAMETERS
//  MEM_TIMEOUT  16  max consecutive MEM_WAIT cycles before HALT (>=1)
//  CNT_W        16  width of saturating performance counters
// PORTS
//  clk_i            in   1      clock, rising edge
//  rst_i            in   1      synchronous active-high reset
//  start_i          in   1      level; pipeline advances only while high
//  ifid_rs_i        in   5      IFID inst[25:21]
//  ifid_rt_i        in   5      IFID inst[20:16]
//  ifid_uses_rt_i   in   1      ID instruction reads rt (R-type, beq, sw)
//  ifid_branch_i    in   1      ID instruction is beq (compares in ID)
//  branch_taken_i   in   1      ID equality compare AND branch
//  jump_i           in   1      ID instruction is j
//  idex_memread_i   in   1      IDEX MemRead
//  idex_regwrite_i  in   1      IDEX RegWrite
//  idex_wreg_i      in   5      IDEX destination (post RegDst mux)
//  exmem_memread_i  in   1      EXMEM MemRead
//  exmem_wreg_i     in   5      EXMEM destination
//  mem_req_i        in   1      EXMEM MemRead|MemWrite
//  mem_ready_i      in   1      data memory completes access this cycle
//  pc_we_o          out  1      PC load enable
//  ifid_we_o        out  1      IFID load enable
//  ifid_flush_o     out  1      IFID loads NOP at next edge
//  idex_bubble_o    out  1      IDEX loads zero controls at next edge
//  exmem_we_o       out  1      IDEX and EXMEM load enable
//  memwb_bubble_o   out  1      MEMWB loads zero controls at next edge
//  err_o            out  1      sticky memory timeout flag
//  stall_cnt_o      out  CNT_W  saturating count of stall cycles
//  flush_cnt_o      out  CNT_W  saturating count of flushes
// BEHAVIOUR
//  States: IDLE, RUN, HZ_STALL, MEM_WAIT, HALT. Reset -> IDLE; counters, err_o, wait timer = 0.
//  Controls are combinational from state+inputs; zero latency, act on the next edge.
//  IDLE: pc/ifid/exmem we=0, bubbles=0, flush=0. start_i=1 -> RUN.
//  start_i=0 in any state except HALT -> IDLE next cycle, same outputs as IDLE.
//  Hazard (reg!=0 match on ifid_rs_i, or ifid_rt_i when uses_rt):
//   load_use = idex_memread & idex_wreg match -> need=1 (need=2 if ifid_branch_i)
//   br_alu   = ifid_branch_i & idex_regwrite & !idex_memread & idex_wreg match -> need=1
//   br_load  = ifid_branch_i & exmem_memread & exmem_wreg match -> need=1
//  Priority: mem_wait > hazard > flush. A stalled branch/jump is not flushed; it is re-evaluated.
//  RUN, mem_req_i & !mem_ready_i: all we=0, memwb_bubble=1 -> MEM_WAIT, timer=1.
//  RUN, hazard: pc_we=ifid_we=0, idex_bubble=1, exmem_we=1; need==1 stays RUN, need==2 -> HZ_STALL.
//  HZ_STALL: one more bubble cycle (same outputs), then -> RUN.
//   mem wait here takes priority: -> MEM_WAIT.
//  RUN, no stall, branch_taken_i|jump_i: ifid_flush=1, all we=1; flush_cnt++.
//  MEM_WAIT: outputs as on entry. mem_ready_i -> RUN with normal RUN outputs this cycle.
//   Else timer++; at timer==MEM_TIMEOUT -> HALT, err_o=1.
//  HALT: all we=0, bubbles=0; only rst_i exits.
//  stall_cnt_o++ each cycle any we=0 in RUN/HZ_STALL/MEM_WAIT; both counters saturate at all-ones.
//  Reset mid-stall/mid-wait: IDLE next edge; no pending stall survives.
// STRUCTURE
//  Shared header pipe_ctrl_defs.vh: state encodings (3-bit localparams), NOP/zero-control
//  constants.
//  Sub-module hazard_detect: combinational compare -> {hazard, need[1:0]}.
// TESTING
//  rst, start=1, lw $2 in EX, ID add $3,$2,$4 -> 1 cycle: pc_we=0, idex_bubble=1, then run.
//  lw $2 in EX, ID beq $2,$5 -> 2 bubble cycles (RUN->HZ_STALL->RUN); stall_cnt_o=2.
//  beq taken, no hazard -> ifid_flush_o=1 one cycle, flush_cnt_o=1; jump likewise -> 2.
//  mem_req=1, ready after 3 cycles -> 3 cycles all we=0, memwb_bubble=1; then resume, err_o=0.
//  mem_req=1, ready never, MEM_TIMEOUT=4 -> HALT after 4 cycles, err_o=1 until rst_i.
//  start_i dropped during MEM_WAIT -> IDLE; rst_i in HZ_STALL -> IDLE, counters 0.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard sequencer.
//   state_t : sequencer states (3-bit encoding)
//   ctrl_t  : per-stage control bundle driven to PC, IFID, IDEX, EXMEM and MEMWB
//   Ctrl*   : the five control patterns the sequencer can emit
package pipe_hazard_ctrl_pkg;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StRun     = 3'd1,
        StHzStall = 3'd2,
        StMemWait = 3'd3,
        StHalt    = 3'd4
    } state_t;

    typedef struct packed {
        logic pc_we;
        logic ifid_we;
        logic ifid_flush;
        logic idex_bubble;
        logic exmem_we;
        logic memwb_bubble;
    } ctrl_t;

    // Everything frozen, nothing injected: used in IDLE and HALT.
    localparam ctrl_t CtrlIdle = '{default: 1'b0};

    localparam ctrl_t CtrlRun = '{pc_we: 1'b1, ifid_we: 1'b1, ifid_flush: 1'b0,
                                  idex_bubble: 1'b0, exmem_we: 1'b1, memwb_bubble: 1'b0};

    // Taken branch or jump: the wrong-path fetch in IFID becomes a NOP.
    localparam ctrl_t CtrlFlush = '{pc_we: 1'b1, ifid_we: 1'b1, ifid_flush: 1'b1,
                                    idex_bubble: 1'b0, exmem_we: 1'b1, memwb_bubble: 1'b0};

    // Operand hazard: hold PC/IFID, let older instructions drain, bubble into EX.
    localparam ctrl_t CtrlBubble = '{pc_we: 1'b0, ifid_we: 1'b0, ifid_flush: 1'b0,
                                     idex_bubble: 1'b1, exmem_we: 1'b1, memwb_bubble: 1'b0};

    // Data memory busy: freeze the whole front end, feed WB a bubble.
    localparam ctrl_t CtrlMemWait = '{pc_we: 1'b0, ifid_we: 1'b0, ifid_flush: 1'b0,
                                      idex_bubble: 1'b0, exmem_we: 1'b0, memwb_bubble: 1'b1};

    localparam logic [4:0] RegZero = 5'd0;
    localparam logic [1:0] NeedNone = 2'd0;
    localparam logic [1:0] NeedOne  = 2'd1;
    localparam logic [1:0] NeedTwo  = 2'd2;

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Combinational operand-hazard detector for the ID stage.
//   ifid_rs/ifid_rt/uses_rt : source registers of the instruction in ID
//   branch                  : ID instruction is beq (operands needed in ID)
//   idex_* / exmem_*        : producer information from the EX and MEM stages
//   hazard                  : ID instruction must be held this cycle
//   need                    : number of bubble cycles required (1 or 2)
module pipe_hazard_ctrl_hazard_detect
    import pipe_hazard_ctrl_pkg::*;
(
    input  logic [4:0] ifid_rs,
    input  logic [4:0] ifid_rt,
    input  logic       uses_rt,
    input  logic       branch,
    input  logic       idex_memread,
    input  logic       idex_regwrite,
    input  logic [4:0] idex_wreg,
    input  logic       exmem_memread,
    input  logic [4:0] exmem_wreg,
    output logic       hazard,
    output logic [1:0] need
);

    logic match_ex;
    logic match_mem;
    logic load_use;
    logic br_alu;
    logic br_load;

    always_comb begin
        // $zero is never a real dependency.
        match_ex  = ((ifid_rs != RegZero) && (ifid_rs == idex_wreg)) ||
                    (uses_rt && (ifid_rt != RegZero) && (ifid_rt == idex_wreg));
        match_mem = ((ifid_rs != RegZero) && (ifid_rs == exmem_wreg)) ||
                    (uses_rt && (ifid_rt != RegZero) && (ifid_rt == exmem_wreg));

        load_use = idex_memread && match_ex;
        br_alu   = branch && idex_regwrite && !idex_memread && match_ex;
        br_load  = branch && exmem_memread && match_mem;

        hazard = load_use || br_alu || br_load;

        // A branch behind a load needs the load to reach WB: two bubbles.
        need = NeedNone;
        if (load_use) begin
            need = branch ? NeedTwo : NeedOne;
        end else if (br_alu || br_load) begin
            need = NeedOne;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer for the 5-stage core: per-stage write-enable/flush/bubble controls.
// Controls are combinational from state and inputs and take effect at the next edge.
//   clk_i, rst_i        : clock, synchronous active-high reset
//   start_i             : pipeline advances only while high
//   ifid_* / idex_* / exmem_* : hazard sources from the pipeline registers
//   branch_taken_i, jump_i    : control transfer resolved in ID
//   mem_req_i, mem_ready_i    : data-memory handshake for the MEM stage
//   pc_we_o .. memwb_bubble_o : stage controls
//   err_o                     : sticky memory-timeout flag
//   stall_cnt_o, flush_cnt_o  : saturating performance counters
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [4:0]       ifid_rs_i,
    input  logic [4:0]       ifid_rt_i,
    input  logic             ifid_uses_rt_i,
    input  logic             ifid_branch_i,
    input  logic             branch_taken_i,
    input  logic             jump_i,
    input  logic             idex_memread_i,
    input  logic             idex_regwrite_i,
    input  logic [4:0]       idex_wreg_i,
    input  logic             exmem_memread_i,
    input  logic [4:0]       exmem_wreg_i,
    input  logic             mem_req_i,
    input  logic             mem_ready_i,
    output logic             pc_we_o,
    output logic             ifid_we_o,
    output logic             ifid_flush_o,
    output logic             idex_bubble_o,
    output logic             exmem_we_o,
    output logic             memwb_bubble_o,
    output logic             err_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    localparam int unsigned TimerW = $clog2(MEM_TIMEOUT + 1);

    state_t             state_q, state_d;
    logic [TimerW-1:0]  timer_q, timer_d, timer_inc;
    logic               err_q, err_d;
    logic [CNT_W-1:0]   stall_cnt_q, flush_cnt_q;
    ctrl_t              ctrl, run_ctrl;
    state_t             run_next;
    logic               hazard, mem_stall, busy, count_stall;
    logic [1:0]         need;

    pipe_hazard_ctrl_hazard_detect u_hazard_detect (
        .ifid_rs       (ifid_rs_i),
        .ifid_rt       (ifid_rt_i),
        .uses_rt       (ifid_uses_rt_i),
        .branch        (ifid_branch_i),
        .idex_memread  (idex_memread_i),
        .idex_regwrite (idex_regwrite_i),
        .idex_wreg     (idex_wreg_i),
        .exmem_memread (exmem_memread_i),
        .exmem_wreg    (exmem_wreg_i),
        .hazard        (hazard),
        .need          (need)
    );

    assign mem_stall = mem_req_i && !mem_ready_i;
    assign timer_inc = timer_q + TimerW'(1);

    // What an advancing pipeline does this cycle: mem wait > hazard > flush.
    always_comb begin
        run_ctrl = CtrlRun;
        run_next = StRun;
        if (mem_stall) begin
            run_ctrl = CtrlMemWait;
            // The entry cycle is already the first wait cycle.
            run_next = (MEM_TIMEOUT <= 1) ? StHalt : StMemWait;
        end else if (hazard) begin
            run_ctrl = CtrlBubble;
            run_next = (need == NeedTwo) ? StHzStall : StRun;
        end else if (branch_taken_i || jump_i) begin
            run_ctrl = CtrlFlush;
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        ctrl    = CtrlIdle;
        busy    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start_i) state_d = StRun;
            end
            StRun: begin
                busy    = 1'b1;
                ctrl    = run_ctrl;
                state_d = run_next;
                if (mem_stall) timer_d = TimerW'(1);
            end
            StHzStall: begin
                busy = 1'b1;
                if (mem_stall) begin
                    ctrl    = run_ctrl;
                    state_d = run_next;
                    timer_d = TimerW'(1);
                end else begin
                    ctrl    = CtrlBubble;
                    state_d = StRun;
                end
            end
            StMemWait: begin
                busy = 1'b1;
                if (mem_ready_i) begin
                    ctrl    = run_ctrl;
                    state_d = run_next;
                end else begin
                    ctrl    = CtrlMemWait;
                    timer_d = timer_inc;
                    if (timer_inc >= TimerW'(MEM_TIMEOUT)) state_d = StHalt;
                end
            end
            StHalt: begin
                state_d = StHalt;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Dropping start abandons any pending stall or wait.
        if (state_q != StHalt && !start_i) begin
            state_d = StIdle;
            ctrl    = CtrlIdle;
            busy    = 1'b0;
        end

        // HALT is only reachable through a memory timeout.
        err_d       = err_q || (state_d == StHalt);
        count_stall = busy && !(ctrl.pc_we && ctrl.ifid_we && ctrl.exmem_we);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            timer_q     <= '0;
            err_q       <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            err_q   <= err_d;
            if (count_stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
            if (ctrl.ifid_flush && (flush_cnt_q != {CNT_W{1'b1}})) begin
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            end
        end
    end

    assign pc_we_o        = ctrl.pc_we;
    assign ifid_we_o      = ctrl.ifid_we;
    assign ifid_flush_o   = ctrl.ifid_flush;
    assign idex_bubble_o  = ctrl.idex_bubble;
    assign exmem_we_o     = ctrl.exmem_we;
    assign memwb_bubble_o = ctrl.memwb_bubble;
    assign err_o          = err_q;
    assign stall_cnt_o    = stall_cnt_q;
    assign flush_cnt_o    = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios with literal expectations,
// then randomized stimulus, all checked every cycle against a behavioural model.
module tb_pipe_hazard_ctrl;

    localparam int T    = 4;
    localparam int CW   = 4;
    localparam int MAXC = (1 << CW) - 1;

    // Output bundle order: {pc_we, ifid_we, ifid_flush, idex_bubble, exmem_we, memwb_bubble}
    localparam logic [5:0] E_IDLE  = 6'b000000;
    localparam logic [5:0] E_RUN   = 6'b110010;
    localparam logic [5:0] E_FLUSH = 6'b111010;
    localparam logic [5:0] E_BUB   = 6'b000110;
    localparam logic [5:0] E_WAIT  = 6'b000001;

    logic clk = 1'b0;
    logic rst, start, uses_rt, branch, taken, jump;
    logic idex_memread, idex_regwrite, exmem_memread, mem_req, mem_ready;
    logic [4:0] rs, rt, idex_wreg, exmem_wreg;
    logic pc_we, ifid_we, ifid_flush, idex_bubble, exmem_we, memwb_bubble, err;
    logic [CW-1:0] stall_cnt, flush_cnt;

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.MEM_TIMEOUT(T), .CNT_W(CW)) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .start_i         (start),
        .ifid_rs_i       (rs),
        .ifid_rt_i       (rt),
        .ifid_uses_rt_i  (uses_rt),
        .ifid_branch_i   (branch),
        .branch_taken_i  (taken),
        .jump_i          (jump),
        .idex_memread_i  (idex_memread),
        .idex_regwrite_i (idex_regwrite),
        .idex_wreg_i     (idex_wreg),
        .exmem_memread_i (exmem_memread),
        .exmem_wreg_i    (exmem_wreg),
        .mem_req_i       (mem_req),
        .mem_ready_i     (mem_ready),
        .pc_we_o         (pc_we),
        .ifid_we_o       (ifid_we),
        .ifid_flush_o    (ifid_flush),
        .idex_bubble_o   (idex_bubble),
        .exmem_we_o      (exmem_we),
        .memwb_bubble_o  (memwb_bubble),
        .err_o           (err),
        .stall_cnt_o     (stall_cnt),
        .flush_cnt_o     (flush_cnt)
    );

    // ---------------- behavioural model ----------------
    // active: pipeline has been started; extra: bubbles still owed; waiting/wcnt: memory wait
    typedef struct packed {
        logic active;
        int   extra;
        logic waiting;
        int   wcnt;
        logic halted;
        logic err;
        int   stall;
        int   flush;
    } ms_t;

    typedef struct packed {
        logic [5:0] ctl;
        ms_t        nxt;
    } res_t;

    ms_t m = '0;

    function automatic int sat(input int x);
        return (x >= MAXC) ? MAXC : x + 1;
    endfunction

    function automatic bit reads(input logic [4:0] r);
        return (r != 5'd0) && ((rs == r) || (uses_rt && (rt == r)));
    endfunction

    function automatic int need_of();
        if (idex_memread && reads(idex_wreg)) return branch ? 2 : 1;
        if (branch && idex_regwrite && reads(idex_wreg)) return 1;
        if (branch && exmem_memread && reads(exmem_wreg)) return 1;
        return 0;
    endfunction

    function automatic res_t model(input ms_t s);
        res_t r;
        int   need;
        r.ctl = E_IDLE;
        r.nxt = s;
        need  = need_of();
        if (s.halted) begin
            r.ctl = E_IDLE;
        end else if (!start) begin
            r.nxt.active  = 1'b0;
            r.nxt.extra   = 0;
            r.nxt.waiting = 1'b0;
        end else if (!s.active) begin
            r.nxt.active = 1'b1;
        end else if ((s.waiting || mem_req) && !mem_ready) begin
            r.ctl         = E_WAIT;
            r.nxt.extra   = 0;
            r.nxt.wcnt    = s.waiting ? s.wcnt + 1 : 1;
            r.nxt.waiting = 1'b1;
            r.nxt.stall   = sat(s.stall);
            if (r.nxt.wcnt >= T) begin
                r.nxt.halted = 1'b1;
                r.nxt.err    = 1'b1;
            end
        end else if (s.extra > 0) begin
            r.ctl       = E_BUB;
            r.nxt.extra = s.extra - 1;
            r.nxt.stall = sat(s.stall);
        end else begin
            r.nxt.waiting = 1'b0;
            if (need > 0) begin
                r.ctl       = E_BUB;
                r.nxt.extra = need - 1;
                r.nxt.stall = sat(s.stall);
            end else if (taken || jump) begin
                r.ctl       = E_FLUSH;
                r.nxt.flush = sat(s.flush);
            end else begin
                r.ctl = E_RUN;
            end
        end
        return r;
    endfunction

    always @(posedge clk) begin
        if (rst) m <= '0;
        else     m <= model(m).nxt;
    end

    // One comparison of the whole output bundle per cycle.
    always @(negedge clk) begin
        res_t r;
        logic [5:0] act_ctl;
        if (chk_en) begin
            r       = model(m);
            act_ctl = {pc_we, ifid_we, ifid_flush, idex_bubble, exmem_we, memwb_bubble};
            n_checks++;
            if (act_ctl !== r.ctl || err !== m.err || stall_cnt !== CW'(m.stall) ||
                flush_cnt !== CW'(m.flush)) begin
                $display("FAIL cycle_cmp t=%0t: got ctl=%b err=%b stall=%0d flush=%0d, want ctl=%b err=%b stall=%0d flush=%0d",
                         $time, act_ctl, err, stall_cnt, flush_cnt, r.ctl, m.err, m.stall,
                         m.flush);
            end else begin
                n_pass++;
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic lit(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        else n_pass++;
    endtask

    task automatic clear_in();
        uses_rt = 1'b0; branch = 1'b0; taken = 1'b0; jump = 1'b0;
        idex_memread = 1'b0; idex_regwrite = 1'b0; exmem_memread = 1'b0;
        mem_req = 1'b0; mem_ready = 1'b0;
        rs = 5'd0; rt = 5'd0; idex_wreg = 5'd0; exmem_wreg = 5'd0;
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0;
        clear_in();
        next();
        chk_en = 1'b1;
        next();
        rst = 1'b0;
        @(negedge clk);
        lit("reset_stall_cnt", int'(stall_cnt), 0);
        lit("reset_err", int'(err), 0);
        lit("reset_pc_we", int'(pc_we), 0);
        next();

        start = 1'b1;
        @(negedge clk); lit("idle_pc_we", int'(pc_we), 0);
        next();
        @(negedge clk); lit("run_pc_we", int'(pc_we), 1);
        next();

        // lw $2 in EX, add $3,$2,$4 in ID
        idex_memread = 1'b1; idex_regwrite = 1'b1; idex_wreg = 5'd2;
        rs = 5'd2; rt = 5'd4; uses_rt = 1'b1;
        @(negedge clk);
        lit("lu_pc_we", int'(pc_we), 0);
        lit("lu_idex_bubble", int'(idex_bubble), 1);
        lit("lu_exmem_we", int'(exmem_we), 1);
        next();
        clear_in();
        @(negedge clk);
        lit("lu_resume_pc_we", int'(pc_we), 1);
        lit("lu_stall_cnt", int'(stall_cnt), 1);
        next();

        // lw $2 in EX, beq $2,$5 in ID: two bubbles
        idex_memread = 1'b1; idex_regwrite = 1'b1; idex_wreg = 5'd2;
        rs = 5'd2; rt = 5'd5; uses_rt = 1'b1; branch = 1'b1;
        @(negedge clk); lit("beq_bubble1", int'(idex_bubble), 1);
        next();
        idex_memread = 1'b0; idex_regwrite = 1'b0; idex_wreg = 5'd0;
        exmem_memread = 1'b1; exmem_wreg = 5'd2;
        @(negedge clk);
        lit("beq_bubble2", int'(idex_bubble), 1);
        lit("beq_bubble2_pc_we", int'(pc_we), 0);
        next();
        exmem_memread = 1'b0; exmem_wreg = 5'd0;
        @(negedge clk);
        lit("beq_resume_pc_we", int'(pc_we), 1);
        lit("beq_stall_cnt", int'(stall_cnt), 3);
        lit("model_stall_pin", m.stall, 3);
        next();

        // taken branch, then jump
        taken = 1'b1;
        @(negedge clk);
        lit("br_flush", int'(ifid_flush), 1);
        lit("br_pc_we", int'(pc_we), 1);
        next();
        clear_in(); jump = 1'b1;
        @(negedge clk);
        lit("j_flush", int'(ifid_flush), 1);
        lit("br_flush_cnt", int'(flush_cnt), 1);
        next();
        jump = 1'b0;
        @(negedge clk);
        lit("j_flush_cnt", int'(flush_cnt), 2);
        lit("model_flush_pin", m.flush, 2);
        next();

        // memory wait of three cycles, then ready
        mem_req = 1'b1; mem_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            lit("mw_pc_we", int'(pc_we), 0);
            lit("mw_memwb_bubble", int'(memwb_bubble), 1);
            next();
        end
        mem_ready = 1'b1;
        @(negedge clk);
        lit("mw_done_pc_we", int'(pc_we), 1);
        lit("mw_done_err", int'(err), 0);
        lit("mw_done_stall_cnt", int'(stall_cnt), 6);
        next();

        // start dropped during a memory wait
        mem_ready = 1'b0;
        next();
        start = 1'b0;
        @(negedge clk);
        lit("drop_memwb_bubble", int'(memwb_bubble), 0);
        lit("drop_pc_we", int'(pc_we), 0);
        next();
        start = 1'b1; mem_req = 1'b0;
        next();

        // reset while in HZ_STALL
        idex_memread = 1'b1; idex_regwrite = 1'b1; idex_wreg = 5'd7;
        rs = 5'd7; branch = 1'b1;
        next();
        rst = 1'b1;
        clear_in();
        next();
        rst = 1'b0;
        @(negedge clk);
        lit("rst_hz_stall_cnt", int'(stall_cnt), 0);
        lit("rst_hz_flush_cnt", int'(flush_cnt), 0);
        lit("rst_hz_idle_pc_we", int'(pc_we), 0);
        next();

        // memory never ready: HALT after T wait cycles
        mem_req = 1'b1; mem_ready = 1'b0;
        for (int k = 0; k < T; k++) begin
            @(negedge clk);
            lit("to_memwb_bubble", int'(memwb_bubble), 1);
            if (k == T - 1) lit("to_err_before_halt", int'(err), 0);
            next();
        end
        @(negedge clk);
        lit("halt_err", int'(err), 1);
        lit("halt_memwb_bubble", int'(memwb_bubble), 0);
        next();
        start = 1'b0; mem_req = 1'b0;
        next();
        start = 1'b1;
        @(negedge clk);
        lit("halt_sticky_err", int'(err), 1);
        lit("halt_pc_we", int'(pc_we), 0);
        next();
        rst = 1'b1;
        next();
        rst = 1'b0;

        // randomized phase; small register range makes matches frequent
        for (int i = 0; i < 3000; i++) begin
            rst           = ($urandom_range(99) < 1);
            start         = ($urandom_range(99) < 95);
            rs            = 5'($urandom_range(3));
            rt            = 5'($urandom_range(3));
            uses_rt       = 1'($urandom_range(1));
            branch        = ($urandom_range(99) < 30);
            taken         = ($urandom_range(99) < 25);
            jump          = ($urandom_range(99) < 15);
            idex_memread  = ($urandom_range(99) < 30);
            idex_regwrite = 1'($urandom_range(1));
            idex_wreg     = 5'($urandom_range(3));
            exmem_memread = ($urandom_range(99) < 30);
            exmem_wreg    = 5'($urandom_range(3));
            mem_req       = ($urandom_range(99) < 25);
            mem_ready     = ($urandom_range(99) < 55);
            next();
        end

        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
